onchip_mem_arbiter: RTL and testbench

- Two-master Avalon-MM arbiter that shares one single-port on-chip RAM between two requesters: 4096 x 32, byteenables, 1-cycle read latency, unregistered RAM output.
- Sits between two system masters (e.g. CPU data port and a DMA/peripheral engine) and the RAM slave's chipselect/write/address interface.
- Round-robin grant, one access per cycle, fixed read latency returned to the owning master.

---
 rtl/onchip_mem_arbiter_pkg.sv | 30 +++
 rtl/onchip_mem_arbiter_if.sv | 35 +++
 rtl/onchip_mem_arbiter_rr_arb2.sv | 121 ++++++++++++
 rtl/onchip_mem_arbiter.sv | 113 +++++++++++
 tb/tb_onchip_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/onchip_mem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// onchip_arb_pkg
// Shared types and defaults for the two-master on-chip RAM arbiter.
//   ADDR_W_DEF / DATA_W_DEF / BE_W_DEF / HOLD_MAX_DEF : default geometry
//   master_id_t : identifies a requester (M0 = 0, M1 = 1)
//   rdv_pipe_t  : one-stage read-return slot {valid, owner}
// ----------------------------------------------------------------------------
package onchip_arb_pkg;

  localparam int ADDR_W_DEF   = 12;
  localparam int DATA_W_DEF   = 32;
  localparam int BE_W_DEF     = 4;
  localparam int HOLD_MAX_DEF = 4;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_id_t;

  typedef struct packed {
    logic       valid;
    master_id_t owner;
  } rdv_pipe_t;

  // The requester that is not 'id'.
  function automatic master_id_t other_master(input master_id_t id);
    return (id == M0) ? M1 : M0;
  endfunction

endpackage

// File: rtl/onchip_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// onchip_mem_arbiter_if
// One Avalon-MM link between a requesting master and the arbiter.
//   address/byteenable/read/write/writedata : driven by the master
//   waitrequest/readdata/readdatavalid      : driven by the arbiter
// Modports: master (requester side), slave (arbiter side).
// ----------------------------------------------------------------------------
interface onchip_mem_arbiter_if
  import onchip_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int BE_W   = BE_W_DEF
) ();

  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/onchip_mem_arbiter_rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant. Grant is combinational from the requests and the
// registered owner of the last accepted command (last_grant).
//   clk, reset_n     : clock, asynchronous active-low reset
//   req_0, req_1     : request from master 0 / master 1
//   grant_0, grant_1 : one-hot grant (both low while reset_n is low)
// Optional macro ONCHIP_ARB_HOLD_EN: the current owner keeps the grant while
// it keeps requesting, for up to HOLD_MAX consecutive accepted beats.
// Without the macro the grant alternates on every contended beat.
// ----------------------------------------------------------------------------
module rr_arb2
  import onchip_arb_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic req_0,
  input  logic req_1,
  output logic grant_0,
  output logic grant_1
);

  if (HOLD_MAX < 1) begin : g_bad_hold
    $error("rr_arb2: HOLD_MAX must be at least 1");
  end

  master_id_t last_grant_r;
  master_id_t last_grant_nxt_s;
  master_id_t winner_s;
  logic       keep_owner_s;

`ifdef ONCHIP_ARB_HOLD_EN
  localparam int CNT_W = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX_C = CNT_W'(HOLD_MAX);

  // hold_cnt_r = consecutive accepted beats of last_grant_r; 0 = run broken.
  logic [CNT_W-1:0] hold_cnt_r;
  logic [CNT_W-1:0] hold_cnt_nxt_s;
  logic             owner_req_s;

  assign owner_req_s  = (last_grant_r == M0) ? req_0 : req_1;
  assign keep_owner_s = owner_req_s && (hold_cnt_r != {CNT_W{1'b0}}) &&
                        (hold_cnt_r < HOLD_MAX_C);

  // Hold counter next state: extend a live run, restart on a new owner,
  // clear when nobody is granted.
  always_comb begin
    hold_cnt_nxt_s = {CNT_W{1'b0}};
    if (grant_0 || grant_1) begin
      if ((last_grant_nxt_s == last_grant_r) && (hold_cnt_r != {CNT_W{1'b0}})) begin
        if (hold_cnt_r == HOLD_MAX_C) begin
          hold_cnt_nxt_s = hold_cnt_r;
        end else begin
          hold_cnt_nxt_s = hold_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end else begin
        hold_cnt_nxt_s = {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      hold_cnt_nxt_s = {CNT_W{1'b0}};
    end
  end

  // Hold counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt_r <= {CNT_W{1'b0}};
    end else begin
      hold_cnt_r <= hold_cnt_nxt_s;
    end
  end
`else
  assign keep_owner_s = 1'b0;
`endif

  // Grant decode; reset_n gates both grants so waitrequest is high in reset.
  always_comb begin
    grant_0  = 1'b0;
    grant_1  = 1'b0;
    winner_s = keep_owner_s ? last_grant_r : other_master(last_grant_r);
    case ({req_1, req_0})
      2'b01: grant_0 = reset_n;
      2'b10: grant_1 = reset_n;
      2'b11: begin
        if (winner_s == M0) begin
          grant_0 = reset_n;
        end else begin
          grant_1 = reset_n;
        end
      end
      default: begin
        grant_0 = 1'b0;
        grant_1 = 1'b0;
      end
    endcase
  end

  // Every grant is an accepted command, so it moves last_grant.
  always_comb begin
    last_grant_nxt_s = last_grant_r;
    if (grant_0) begin
      last_grant_nxt_s = M0;
    end else if (grant_1) begin
      last_grant_nxt_s = M1;
    end else begin
      last_grant_nxt_s = last_grant_r;
    end
  end

  // Last-grant register; resets to M1 so M0 wins the first contention.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_r <= M1;
    end else begin
      last_grant_r <= last_grant_nxt_s;
    end
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// ----------------------------------------------------------------------------
// onchip_mem_arbiter
// Shares one single-port on-chip RAM (1-cycle read latency) between two
// Avalon-MM masters with round-robin grant, one access per cycle.
//   clk, reset_n       : clock, asynchronous active-low reset
//   m0, m1             : master links (onchip_mem_arbiter_if.slave)
//   mem_address/byteenable/chipselect/write/writedata/clken : RAM command
//   mem_readdata       : RAM read data, valid one cycle after the address
// Optional macro ONCHIP_ARB_HOLD_EN enables grant holding in rr_arb2.
// ----------------------------------------------------------------------------
module onchip_mem_arbiter
  import onchip_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int BE_W     = BE_W_DEF,
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  onchip_mem_arbiter_if.slave m0,
  onchip_mem_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [BE_W-1:0]     mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  logic      req_0_s, req_1_s;
  logic      rd_0_s, rd_1_s;
  logic      grant_0_s, grant_1_s;
  rdv_pipe_t rdv_pipe_r;
  rdv_pipe_t rdv_pipe_nxt_s;

  // Read+write together counts as a write; the read half is dropped.
  assign req_0_s = m0.read | m0.write;
  assign req_1_s = m1.read | m1.write;
  assign rd_0_s  = m0.read & ~m0.write;
  assign rd_1_s  = m1.read & ~m1.write;

  rr_arb2 #(
    .HOLD_MAX (HOLD_MAX)
  ) u_rr_arb2 (
    .clk     (clk),
    .reset_n (reset_n),
    .req_0   (req_0_s),
    .req_1   (req_1_s),
    .grant_0 (grant_0_s),
    .grant_1 (grant_1_s)
  );

  assign m0.waitrequest = ~grant_0_s;
  assign m1.waitrequest = ~grant_1_s;

  assign mem_chipselect = grant_0_s | grant_1_s;
  assign mem_clken      = reset_n;

  // RAM command mux; all zero when nobody is granted.
  always_comb begin
    mem_address    = {ADDR_W{1'b0}};
    mem_byteenable = {BE_W{1'b0}};
    mem_write      = 1'b0;
    mem_writedata  = {DATA_W{1'b0}};
    case ({grant_1_s, grant_0_s})
      2'b01: begin
        mem_address    = m0.address;
        mem_byteenable = m0.byteenable;
        mem_write      = m0.write;
        mem_writedata  = m0.writedata;
      end
      2'b10: begin
        mem_address    = m1.address;
        mem_byteenable = m1.byteenable;
        mem_write      = m1.write;
        mem_writedata  = m1.writedata;
      end
      default: begin
        mem_address    = {ADDR_W{1'b0}};
        mem_byteenable = {BE_W{1'b0}};
        mem_write      = 1'b0;
        mem_writedata  = {DATA_W{1'b0}};
      end
    endcase
  end

  // Read-return slot: tag the accepted read with its owner.
  always_comb begin
    rdv_pipe_nxt_s.valid = (grant_0_s & rd_0_s) | (grant_1_s & rd_1_s);
    if (grant_1_s) begin
      rdv_pipe_nxt_s.owner = M1;
    end else begin
      rdv_pipe_nxt_s.owner = M0;
    end
  end

  // Read-return register; reset cancels any in-flight return.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdv_pipe_r <= '{valid: 1'b0, owner: M0};
    end else begin
      rdv_pipe_r <= rdv_pipe_nxt_s;
    end
  end

  assign m0.readdatavalid = rdv_pipe_r.valid && (rdv_pipe_r.owner == M0);
  assign m1.readdatavalid = rdv_pipe_r.valid && (rdv_pipe_r.owner == M1);
  assign m0.readdata      = mem_readdata;
  assign m1.readdata      = mem_readdata;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_onchip_mem_arbiter
// Directed bench for onchip_mem_arbiter with a behavioural RAM and a read
// scoreboard (expected {owner, data} queued at accept, popped on
// readdatavalid). Covers the ONCHIP_ARB_HOLD_EN build when that macro is set.
// ----------------------------------------------------------------------------
module tb_onchip_mem_arbiter;
  import onchip_arb_pkg::*;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int HM = 4;
`ifdef ONCHIP_ARB_HOLD_EN
  localparam int RR_N    = 12;
  localparam int RR_ACC0 = 8;
  localparam int RR_ACC1 = 4;
`else
  localparam int RR_N    = 8;
  localparam int RR_ACC0 = 4;
  localparam int RR_ACC1 = 4;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  onchip_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) m0_if ();
  onchip_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) m1_if ();

  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_byteenable;
  logic          mem_chipselect;
  logic          mem_write;
  logic [DW-1:0] mem_writedata;
  logic          mem_clken;
  logic [DW-1:0] mem_readdata;

  onchip_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .HOLD_MAX(HM)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .m0             (m0_if),
    .m1             (m1_if),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata)
  );

  // Background content of a word never written by the bench.
  function automatic logic [31:0] pattern(input int a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  // Behavioural RAM: 1-cycle read latency, byte-lane writes.
  logic [31:0] ram [0:4095];
  logic        written [0:4095];
  logic [31:0] ram_q = 32'h0;
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_byteenable[b]) begin
            ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
          end
        end
        written[mem_address] <= 1'b1;
      end else begin
        ram_q <= written[mem_address] ? ram[mem_address] : pattern(int'(mem_address));
      end
    end
  end
  assign mem_readdata = ram_q;

  int n_checks = 0;
  int n_pass   = 0;
  bit          exp_owner_q[$];
  logic [31:0] exp_data_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic set_m(input int m, input bit rd, input bit wr, input logic [11:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    if (m == 0) begin
      m0_if.read = rd; m0_if.write = wr; m0_if.address = a;
      m0_if.writedata = d; m0_if.byteenable = be;
    end else begin
      m1_if.read = rd; m1_if.write = wr; m1_if.address = a;
      m1_if.writedata = d; m1_if.byteenable = be;
    end
  endtask

  task automatic idle_all();
    set_m(0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    set_m(1, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rd(input bit owner, input logic [31:0] d);
    exp_owner_q.push_back(owner);
    exp_data_q.push_back(d);
  endtask

  // Scoreboard: each readdatavalid pops the oldest expected read.
  always @(negedge clk) begin
    if (m0_if.readdatavalid || m1_if.readdatavalid) begin
      chk("rdv_onehot", 32'(m0_if.readdatavalid & m1_if.readdatavalid), 32'h0);
      if (exp_owner_q.size() == 0) begin
        chk("rdv_unexpected", 32'h1, 32'h0);
      end else begin
        chk("rdv_owner", 32'(m1_if.readdatavalid), 32'(exp_owner_q.pop_front()));
        chk("rdv_data", m1_if.readdatavalid ? m1_if.readdata : m0_if.readdata,
            exp_data_q.pop_front());
      end
    end
  end

  initial begin
    int a0, a1, acc0, acc1;
    bit exp_m1;
    for (int i = 0; i < 4096; i++) written[i] = 1'b0;

    // Reset: a pending request must still see waitrequest high.
    reset_n = 1'b0;
    idle_all();
    set_m(0, 1'b1, 1'b0, 12'h001, 32'h0, 4'hF);
    @(negedge clk);
    chk("rst_wait0", 32'(m0_if.waitrequest), 32'h1);
    chk("rst_wait1", 32'(m1_if.waitrequest), 32'h1);
    chk("rst_cs", 32'(mem_chipselect), 32'h0);
    chk("rst_clken", 32'(mem_clken), 32'h0);
    chk("rst_rdv0", 32'(m0_if.readdatavalid), 32'h0);
    idle_all();
    @(negedge clk);
    reset_n = 1'b1;
    next_cycle();

    // Idle after reset.
    @(negedge clk);
    chk("idle_wait0", 32'(m0_if.waitrequest), 32'h1);
    chk("idle_cs", 32'(mem_chipselect), 32'h0);
    chk("idle_addr", 32'(mem_address), 32'h0);
    chk("idle_clken", 32'(mem_clken), 32'h1);
    next_cycle();

    // Single master write then read.
    set_m(0, 1'b0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    chk("t1_wr_wait0", 32'(m0_if.waitrequest), 32'h0);
    chk("t1_wr_wait1", 32'(m1_if.waitrequest), 32'h1);
    chk("t1_wr_cs", 32'(mem_chipselect), 32'h1);
    chk("t1_wr_we", 32'(mem_write), 32'h1);
    chk("t1_wr_addr", 32'(mem_address), 32'h010);
    chk("t1_wr_data", mem_writedata, 32'hDEADBEEF);
    chk("t1_wr_be", 32'(mem_byteenable), 32'hF);
    next_cycle();
    set_m(0, 1'b1, 1'b0, 12'h010, 32'h0, 4'hF);
    @(negedge clk);
    chk("t1_rd_wait0", 32'(m0_if.waitrequest), 32'h0);
    chk("t1_rd_we", 32'(mem_write), 32'h0);
    expect_rd(1'b0, 32'hDEADBEEF);
    next_cycle();

    // Read+write together is a write only: no read return.
    set_m(0, 1'b1, 1'b1, 12'h020, 32'h12345678, 4'hF);
    @(negedge clk);
    chk("rw_we", 32'(mem_write), 32'h1);
    chk("rw_addr", 32'(mem_address), 32'h020);
    next_cycle();
    idle_all();

    // Byte lanes from master 1.
    set_m(1, 1'b0, 1'b1, 12'h010, 32'h0000AAAA, 4'h3);
    @(negedge clk);
    chk("t2_wr_wait1", 32'(m1_if.waitrequest), 32'h0);
    chk("t2_wr_be", 32'(mem_byteenable), 32'h3);
    chk("t2_wr_data", mem_writedata, 32'h0000AAAA);
    next_cycle();
    set_m(1, 1'b1, 1'b0, 12'h010, 32'h0, 4'hF);
    @(negedge clk);
    chk("t2_rd_wait1", 32'(m1_if.waitrequest), 32'h0);
    expect_rd(1'b1, 32'hDEADAAAA);
    next_cycle();

    // Contention with last grant = m1: m0 first, then m1.
    set_m(0, 1'b1, 1'b0, 12'h001, 32'h0, 4'hF);
    set_m(1, 1'b1, 1'b0, 12'h002, 32'h0, 4'hF);
    @(negedge clk);
    chk("t3_c0_wait0", 32'(m0_if.waitrequest), 32'h0);
    chk("t3_c0_wait1", 32'(m1_if.waitrequest), 32'h1);
    chk("t3_c0_addr", 32'(mem_address), 32'h001);
    expect_rd(1'b0, pattern(1));
    next_cycle();
    set_m(0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk("t3_c1_wait1", 32'(m1_if.waitrequest), 32'h0);
    chk("t3_c1_addr", 32'(mem_address), 32'h002);
    expect_rd(1'b1, pattern(2));
    next_cycle();
    idle_all();
    next_cycle();

    // Sustained contention: both masters read every cycle.
    a0 = 0; a1 = 0; acc0 = 0; acc1 = 0;
    for (int c = 0; c < RR_N; c++) begin
`ifdef ONCHIP_ARB_HOLD_EN
      exp_m1 = ((c / HM) % 2) == 1;
`else
      exp_m1 = (c % 2) == 1;
`endif
      set_m(0, 1'b1, 1'b0, 12'(256 + a0), 32'h0, 4'hF);
      set_m(1, 1'b1, 1'b0, 12'(512 + a1), 32'h0, 4'hF);
      @(negedge clk);
      chk("rr_wait0", 32'(m0_if.waitrequest), 32'(exp_m1));
      chk("rr_wait1", 32'(m1_if.waitrequest), 32'(!exp_m1));
      chk("rr_cs", 32'(mem_chipselect), 32'h1);
      if (!m0_if.waitrequest) acc0++;
      if (!m1_if.waitrequest) acc1++;
      if (exp_m1) begin
        expect_rd(1'b1, pattern(512 + a1));
        a1++;
      end else begin
        expect_rd(1'b0, pattern(256 + a0));
        a0++;
      end
      next_cycle();
    end
    idle_all();
    chk("rr_acc0", 32'(acc0), 32'(RR_ACC0));
    chk("rr_acc1", 32'(acc1), 32'(RR_ACC1));
    repeat (2) next_cycle();

    // Reset mid-read: accepted read is cancelled.
    set_m(0, 1'b1, 1'b0, 12'h003, 32'h0, 4'hF);
    @(negedge clk);
    chk("mr_acc", 32'(m0_if.waitrequest), 32'h0);
    #1;
    reset_n = 1'b0;
    idle_all();
    @(negedge clk);
    chk("mr_rdv0", 32'(m0_if.readdatavalid), 32'h0);
    chk("mr_wait0", 32'(m0_if.waitrequest), 32'h1);
    @(negedge clk);
    reset_n = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("mr_rdv0_after", 32'(m0_if.readdatavalid), 32'h0);
    next_cycle();

    // First contention after reset goes to m0.
    set_m(0, 1'b1, 1'b0, 12'h004, 32'h0, 4'hF);
    set_m(1, 1'b1, 1'b0, 12'h005, 32'h0, 4'hF);
    @(negedge clk);
    chk("pr_c0_wait0", 32'(m0_if.waitrequest), 32'h0);
    chk("pr_c0_wait1", 32'(m1_if.waitrequest), 32'h1);
    expect_rd(1'b0, pattern(4));
    next_cycle();
`ifdef ONCHIP_ARB_HOLD_EN
    // Owner keeps the grant for a second beat, then drops its request.
    set_m(0, 1'b1, 1'b0, 12'h006, 32'h0, 4'hF);
    @(negedge clk);
    chk("hd_c1_wait0", 32'(m0_if.waitrequest), 32'h0);
    chk("hd_c1_wait1", 32'(m1_if.waitrequest), 32'h1);
    expect_rd(1'b0, pattern(6));
    next_cycle();
`endif
    set_m(0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk("pr_m1_wait1", 32'(m1_if.waitrequest), 32'h0);
    chk("pr_m1_addr", 32'(mem_address), 32'h005);
    expect_rd(1'b1, pattern(5));
    next_cycle();
    idle_all();

    repeat (3) next_cycle();
    chk("sb_empty", 32'(exp_owner_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
